uart_tx_param: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8E1 transmitter in the UART path. It adds configurable data width, parity mode and stop-bit count, and replaces the derived baud clock with a clock-enable tick in the `clk` domain. A valid/ready input handshake and a one-entry holding register allow back-to-back frames with no idle gap. It sits between the FPGA control logic and the serial line, alongside `uart_rx`.

---
 rtl/uart_tx_param_pkg.sv | 27 ++
 rtl/uart_tx_param_baud_tick.sv | 36 +++
 rtl/uart_tx_param.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_param_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_param_pkg                                                        |
// | Shared UART constants: shifter state encoding, parity modes, baud rates. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package uart_tx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Baud settings expressed as clk cycles per bit at a 24 MHz system clock.
  localparam int BAUD6M_CLK24M = 4;
  localparam int BAUD3M_CLK24M = 8;
  localparam int BAUD1M_CLK24M = 24;

endpackage
`default_nettype wire

// File: rtl/uart_tx_param_baud_tick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_baud_tick                                                           |
// | Bit-period counter giving a one-cycle tick at terminal count.            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module uart_baud_tick
  import uart_tx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD6M_CLK24M
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_param                                                            |
// | Parametrised UART transmitter with valid/ready input and 1-entry hold.   |
// | Optional parity bit compiled in with macro UART_TX_PARITY_EN.            |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = PARITY_EVEN,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = BAUD6M_CLK24M
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 tx,
  output logic                 tx_busy
);

`ifdef UART_TX_PARITY_EN
  localparam bit c_par_built = 1'b1;
`else
  localparam bit c_par_built = 1'b0;
`endif
  localparam bit         c_par_en    = c_par_built && (PARITY_MODE != PARITY_NONE);
  localparam logic [3:0] c_data_last = 4'(DATA_BITS - 1);
  localparam logic [3:0] c_stop_last = 4'(STOP_BITS - 1);

  tx_state_t            r_state, w_state_nx;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_hold_data;
  logic [DATA_BITS-1:0] r_shift, w_shift_nx;
  logic [3:0]           r_idx, w_idx_nx;
  logic                 r_tx, w_tx_nx;
  logic                 w_load;
  logic                 w_xfer;
  logic                 w_tick;
  logic                 w_restart;

  assign w_xfer    = data_valid & ~r_hold_full;
  assign w_restart = (r_state == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .restart(w_restart),
    .tick   (w_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par;
  logic w_par_nx;

  // Parity is taken from the held word at load time, never from data_in.
  assign w_par_nx = (PARITY_MODE == PARITY_ODD) ? ~^r_hold_data : ^r_hold_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= w_par_nx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_idx_nx   = r_idx;
    w_tx_nx    = r_tx;
    w_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nx = 1'b1;
        if (r_hold_full) w_load = 1'b1;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nx = ST_DATA;
          w_idx_nx   = '0;
          w_tx_nx    = r_shift[0];
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_idx == c_data_last) begin
            w_idx_nx = '0;
            if (c_par_en) begin
`ifdef UART_TX_PARITY_EN
              w_state_nx = ST_PARITY;
              w_tx_nx    = r_par;
`endif
            end else begin
              w_state_nx = ST_STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_idx_nx   = r_idx + 4'd1;
            w_shift_nx = r_shift >> 1;
            w_tx_nx    = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nx = ST_STOP;
          w_tx_nx    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_idx == c_stop_last) begin
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
              w_state_nx = ST_IDLE;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_idx_nx = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
    // A load starts a fresh frame from either IDLE or the final stop cycle.
    if (w_load) begin
      w_state_nx = ST_START;
      w_shift_nx = r_hold_data;
      w_idx_nx   = '0;
      w_tx_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_shift     <= '0;
      r_idx       <= '0;
      r_tx        <= 1'b1;
    end else begin
      r_shift <= w_shift_nx;
      r_idx   <= w_idx_nx;
      r_tx    <= w_tx_nx;
      if (w_xfer) begin
        r_hold_full <= 1'b1;
        r_hold_data <= data_in;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign data_ready = ~r_hold_full;
  assign tx         = r_tx;
  assign tx_busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_param                                                         |
// | Randomised self-checking bench for two uart_tx_param configurations.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_uart_tx_param;
  import uart_tx_param_pkg::*;

  localparam int A_DB = 8, A_PM = PARITY_EVEN, A_SB = 1, A_CPB = 4;
  localparam int B_DB = 7, B_PM = PARITY_ODD,  B_SB = 2, B_CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif
  localparam bit A_PEN = PAR_BUILT && (A_PM != PARITY_NONE);
  localparam bit B_PEN = PAR_BUILT && (B_PM != PARITY_NONE);
  localparam int A_LEN = A_CPB * (1 + A_DB + (A_PEN ? 1 : 0) + A_SB);
  localparam int B_LEN = B_CPB * (1 + B_DB + (B_PEN ? 1 : 0) + B_SB);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a_data = '0;
  logic       a_valid = 1'b0, a_ready, a_tx, a_busy;
  logic [6:0] b_data = '0;
  logic       b_valid = 1'b0, b_ready, b_tx, b_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  uart_tx_param #(.DATA_BITS(A_DB), .PARITY_MODE(A_PM), .STOP_BITS(A_SB), .CLKS_PER_BIT(A_CPB)) dut_a (
    .clk(clk), .reset(reset), .data_in(a_data), .data_valid(a_valid),
    .data_ready(a_ready), .tx(a_tx), .tx_busy(a_busy));

  uart_tx_param #(.DATA_BITS(B_DB), .PARITY_MODE(B_PM), .STOP_BITS(B_SB), .CLKS_PER_BIT(B_CPB)) dut_b (
    .clk(clk), .reset(reset), .data_in(b_data), .data_valid(b_valid),
    .data_ready(b_ready), .tx(b_tx), .tx_busy(b_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: ideal line waveform of one frame, one entry per clk cycle.
  function automatic logic [63:0] exp_wave(input logic [8:0] d, input int db, input bit pen,
                                           input bit odd, input int sb, input int cpb);
    logic [15:0] bits;
    logic [63:0] w;
    int n, ones;
    bits = '0; n = 0; ones = 0;
    bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < db; i++) begin
      bits[n] = d[i];
      ones = ones + int'(d[i]);
      n = n + 1;
    end
    if (pen) begin
      bits[n] = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      n = n + 1;
    end
    for (int i = 0; i < sb; i++) begin
      bits[n] = 1'b1;
      n = n + 1;
    end
    w = '0;
    for (int k = 0; k < n * cpb; k++) w[k] = bits[k / cpb];
    return w;
  endfunction

  function automatic logic [63:0] exp_a(input logic [8:0] d);
    return exp_wave(d, A_DB, A_PEN, A_PM == PARITY_ODD, A_SB, A_CPB);
  endfunction

  function automatic logic [63:0] exp_b(input logic [8:0] d);
    return exp_wave(d, B_DB, B_PEN, B_PM == PARITY_ODD, B_SB, B_CPB);
  endfunction

  // Line monitors: capture each frame from its falling start edge.
  logic [63:0] cap_a[$], cap_b[$];
  int          cap_a_t[$], cap_b_t[$];
  logic [63:0] a_buf, b_buf;
  int          a_cnt, b_cnt, a_st, b_st;
  bit          a_in = 1'b0, b_in = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      a_in = 1'b0;
      b_in = 1'b0;
    end else begin
      if (!a_in) begin
        if (a_tx === 1'b0) begin a_in = 1'b1; a_buf = '0; a_cnt = 1; a_st = cyc; end
      end else begin
        a_buf[a_cnt] = a_tx; a_cnt = a_cnt + 1;
      end
      if (a_in && a_cnt == A_LEN) begin cap_a.push_back(a_buf); cap_a_t.push_back(a_st); a_in = 1'b0; end
      if (!b_in) begin
        if (b_tx === 1'b0) begin b_in = 1'b1; b_buf = '0; b_cnt = 1; b_st = cyc; end
      end else begin
        b_buf[b_cnt] = b_tx; b_cnt = b_cnt + 1;
      end
      if (b_in && b_cnt == B_LEN) begin cap_b.push_back(b_buf); cap_b_t.push_back(b_st); b_in = 1'b0; end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_caps();
    cap_a.delete(); cap_a_t.delete(); cap_b.delete(); cap_b_t.delete();
  endtask

  // Offer a word and return once it is accepted; valid stays high afterwards.
  task automatic offer(input bit which, input logic [8:0] w, output int acc);
    bit rdy;
    if (which) begin b_data = w[6:0]; b_valid = 1'b1; end
    else       begin a_data = w[7:0]; a_valid = 1'b1; end
    rdy = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((which ? b_ready : a_ready) === 1'b1) begin rdy = 1'b1; break; end
      tick_n(1);
    end
    if (!rdy) begin
      n_checks++;
      $display("FAIL offer_timeout dut=%0d word=%h: data_ready never rose, need 1", which, w);
    end
    tick_n(1);
    acc = cyc;
  endtask

  task automatic wait_cap(input bit which, input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if ((which ? cap_b.size() : cap_a.size()) >= n) begin ok = 1'b1; break; end
      tick_n(1);
    end
  endtask

  task automatic test_reset();
    a_valid = 1'b1; a_data = 8'h3C;
    tick_n(4);
    n_checks++; if (a_tx !== 1'b1) $display("FAIL rst_tx_a got=%b need=1", a_tx); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL rst_busy_a got=%b need=0", a_busy); else n_pass++;
    n_checks++; if (a_ready !== 1'b1) $display("FAIL rst_ready_a got=%b need=1", a_ready); else n_pass++;
    n_checks++; if ({b_tx, b_busy, b_ready} !== 3'b101)
      $display("FAIL rst_b got tx/busy/ready=%b need=101", {b_tx, b_busy, b_ready}); else n_pass++;
    reset = 1'b0; a_valid = 1'b0;
    tick_n(60);
    n_checks++; if (cap_a.size() != 0) $display("FAIL rst_handshake_ignored frames=%0d need=0", cap_a.size()); else n_pass++;
    n_checks++; if (a_ready !== 1'b1) $display("FAIL rst_hold_empty ready=%b need=1", a_ready); else n_pass++;
  endtask

  task automatic test_frame_timing();
    int acc; bit ok;
    clear_caps();
    offer(1'b0, 9'h0A5, acc);
    a_valid = 1'b0;
    tick_n(1);
    n_checks++; if (a_tx !== 1'b0) $display("FAIL start_latency tx=%b need=0", a_tx); else n_pass++;
    n_checks++; if (a_busy !== 1'b1) $display("FAIL busy_rise got=%b need=1", a_busy); else n_pass++;
    wait_cap(1'b0, 1, A_LEN + 20, ok);
    n_checks++; if (!ok) $display("FAIL frame_a5_timeout frames=0 need=1"); else n_pass++;
    if (ok) begin
      n_checks++; if (cap_a[0] !== exp_a(9'h0A5))
        $display("FAIL wave_a5 got=%h need=%h", cap_a[0], exp_a(9'h0A5)); else n_pass++;
      n_checks++; if (cap_a_t[0] != acc + 1)
        $display("FAIL start_cycle got=%0d need=%0d", cap_a_t[0], acc + 1); else n_pass++;
      n_checks++; if (a_busy !== 1'b1) $display("FAIL busy_last_stop got=%b need=1", a_busy); else n_pass++;
      tick_n(1);
      n_checks++; if ({a_busy, a_tx} !== 2'b01)
        $display("FAIL busy_fall got busy/tx=%b need=01", {a_busy, a_tx}); else n_pass++;
    end
  endtask

  task automatic test_parity();
    logic [8:0] w; bit which; int acc; bit ok;
    for (int i = 0; i < 7; i++) begin
      clear_caps();
      case (i)
        0: begin which = 1'b0; w = 9'h000; end
        1: begin which = 1'b0; w = 9'h001; end
        2: begin which = 1'b1; w = 9'h000; end
        default: begin which = i[0]; w = 9'($urandom_range(0, 511)); end
      endcase
      if (which) w = w & 9'h07F; else w = w & 9'h0FF;
      offer(which, w, acc);
      a_valid = 1'b0; b_valid = 1'b0;
      wait_cap(which, 1, 2 * B_LEN + 20, ok);
      n_checks++;
      if (!ok) $display("FAIL parity_timeout case=%0d frames=0 need=1", i);
      else if (which ? (cap_b[0] !== exp_b(w)) : (cap_a[0] !== exp_a(w)))
        $display("FAIL parity_wave case=%0d word=%h got=%h need=%h", i, w,
                 which ? cap_b[0] : cap_a[0], which ? exp_b(w) : exp_a(w));
      else n_pass++;
      tick_n(3);
    end
  endtask

  task automatic test_seven_bit();
    int acc; bit ok;
    clear_caps();
    offer(1'b1, 9'h07F, acc);
    b_valid = 1'b0;
    wait_cap(1'b1, 1, B_LEN + 20, ok);
    n_checks++; if (!ok) $display("FAIL seven_timeout frames=0 need=1"); else n_pass++;
    if (ok) begin
      n_checks++; if (cap_b[0] !== exp_b(9'h07F))
        $display("FAIL seven_wave got=%h need=%h", cap_b[0], exp_b(9'h07F)); else n_pass++;
      n_checks++; if (b_busy !== 1'b1) $display("FAIL seven_busy_last got=%b need=1", b_busy); else n_pass++;
      tick_n(1);
      n_checks++; if (b_busy !== 1'b0) $display("FAIL seven_busy_fall got=%b need=0", b_busy); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int acc0, acc1; bit ok;
    clear_caps();
    offer(1'b0, 9'h055, acc0);
    n_checks++; if (a_ready !== 1'b0) $display("FAIL b2b_ready_low got=%b need=0", a_ready); else n_pass++;
    offer(1'b0, 9'h00F, acc1);
    a_valid = 1'b0;
    wait_cap(1'b0, 2, 3 * A_LEN, ok);
    n_checks++; if (!ok) $display("FAIL b2b_timeout frames=%0d need=2", cap_a.size()); else n_pass++;
    if (ok) begin
      n_checks++; if (cap_a[0] !== exp_a(9'h055)) $display("FAIL b2b_wave0 got=%h need=%h", cap_a[0], exp_a(9'h055)); else n_pass++;
      n_checks++; if (cap_a[1] !== exp_a(9'h00F)) $display("FAIL b2b_wave1 got=%h need=%h", cap_a[1], exp_a(9'h00F)); else n_pass++;
      n_checks++; if (cap_a_t[1] - cap_a_t[0] != A_LEN)
        $display("FAIL b2b_spacing got=%0d need=%0d", cap_a_t[1] - cap_a_t[0], A_LEN); else n_pass++;
    end
    tick_n(3);
  endtask

  task automatic test_back_pressure();
    logic [8:0] words[4]; int acc; bit ok;
    clear_caps();
    foreach (words[i]) words[i] = 9'($urandom_range(0, 127));
    foreach (words[i]) offer(1'b1, words[i], acc);
    b_valid = 1'b0;
    wait_cap(1'b1, 4, 5 * B_LEN, ok);
    tick_n(B_LEN + 10);
    n_checks++; if (cap_b.size() != 4) $display("FAIL bp_count got=%0d need=4", cap_b.size()); else n_pass++;
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (cap_b[i] !== exp_b(words[i]))
          $display("FAIL bp_wave%0d got=%h need=%h", i, cap_b[i], exp_b(words[i])); else n_pass++;
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++; if (cap_b_t[i] - cap_b_t[i-1] != B_LEN)
          $display("FAIL bp_gap%0d got=%0d need=%0d", i, cap_b_t[i] - cap_b_t[i-1], B_LEN); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    clear_caps();
    offer(1'b0, 9'($urandom_range(0, 255)), acc);
    offer(1'b0, 9'($urandom_range(0, 255)), acc);
    a_valid = 1'b0;
    tick_n(8);
    n_checks++; if ({a_busy, a_ready} !== 2'b10)
      $display("FAIL midrst_pre got busy/ready=%b need=10", {a_busy, a_ready}); else n_pass++;
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    n_checks++; if (a_tx !== 1'b1) $display("FAIL midrst_tx got=%b need=1", a_tx); else n_pass++;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL midrst_busy got=%b need=0", a_busy); else n_pass++;
    n_checks++; if (a_ready !== 1'b1) $display("FAIL midrst_ready got=%b need=1", a_ready); else n_pass++;
    clear_caps();
    tick_n(2 * A_LEN);
    n_checks++; if (cap_a.size() != 0) $display("FAIL midrst_discard frames=%0d need=0", cap_a.size()); else n_pass++;
    n_checks++; if (a_tx !== 1'b1) $display("FAIL midrst_idle_tx got=%b need=1", a_tx); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_parity();
    test_seven_bit();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
